tile_drain: RTL and testbench
=============================

TILE_DRAIN -- requirements
Module: tile_drain

Interface
REQ-001 Parameter M, default 64: number of systolic tile rows, which is also the number of output beats.
REQ-002 Parameter N, default 64: number of systolic tile columns, which is also the number of elements per beat.
REQ-003 Parameter INPUT_WIDTH, default 16: MAC operand width; each accumulator is 2*INPUT_WIDTH bits, signed two's complement.
REQ-004 Parameter OUT_WIDTH, default 2*INPUT_WIDTH: emitted element width, legal range 2..2*INPUT_WIDTH.
REQ-005 Port clk, input, 1: sole clock, rising edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port start, input, 1: pulse meaning tile accumulators are final; request drain.
REQ-008 Port acc_in, input, [0:M*N*2*INPUT_WIDTH-1]: flat tile accumulator bus; element (i,j) at bit offset (i*N+j)*2*INPUT_WIDTH, MSB-first slice.
REQ-009 Port tile_freeze, output, 1: holds tile enable low while draining.
REQ-010 Port tile_clr, output, 1: one-cycle pulse that clears the tile accumulators after the drain.
REQ-011 Port busy, output, 1: high in any state other than IDLE.
REQ-012 Port out_data, output, [0:N*OUT_WIDTH-1]: one tile row per beat; element j at bit offset j*OUT_WIDTH.
REQ-013 Port out_row, output, max(1,$clog2(M)): row index of the current beat.
REQ-014 Port out_valid, output, 1: beat valid.
REQ-015 Port out_ready, input, 1: sink accepts the beat.
REQ-016 Port out_last, output, 1: the current beat is row M-1.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, DRAIN, CLEAR.
REQ-018 In IDLE with start=1, the next edge SHALL register row 0 into out_data, set out_row=0, out_valid=1, out_last=(M==1), an internal row counter to 1, tile_freeze=1, and state to DRAIN, giving a first-beat latency of 1 cycle.
REQ-019 start SHALL be ignored in DRAIN and CLEAR.
REQ-020 A handshake occurs on any edge where out_valid=1 and out_ready=1.
REQ-021 While out_valid=1 and out_ready=0, out_data, out_row and out_last SHALL hold stable.
REQ-022 In DRAIN, on an edge with a handshake and counter<M, the output register SHALL load row counter and the counter SHALL increment, sustaining one beat per cycle with out_ready held high.
REQ-023 On a handshake with out_last=1, the next edge SHALL drop out_valid and enter CLEAR.
REQ-024 CLEAR SHALL last one cycle with tile_clr=1 and tile_freeze=1, then return to IDLE with tile_freeze=0.
REQ-025 Narrowing: when OUT_WIDTH<2*INPUT_WIDTH, each element SHALL saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; otherwise it passes unchanged.
REQ-026 acc_in SHALL be stable from the start cycle through CLEAR; this is the integrator's obligation, and the block captures no snapshot.
REQ-027 Beats SHALL be emitted in strictly increasing row order 0..M-1, with no gaps and no repeats.

Reset
REQ-028 rst=1 SHALL force IDLE, counter=0, and all outputs to 0 (out_data, out_row, out_valid, out_last, tile_freeze, tile_clr, busy).
REQ-029 rst asserted during DRAIN or CLEAR SHALL abort the drain without a tile_clr pulse; rst takes priority over start.

Structure
REQ-030 The state enum typedef SHALL reside in the shared package tpu_pkg.
REQ-031 Element narrowing SHALL be a sub-module sat_narrow (parameters IN_W, OUT_W), instantiated N times in a generate loop.

Verification (M=2, N=2, INPUT_WIDTH=4 unless stated)
REQ-032 Case: acc (0,0)=0x11, (0,1)=0x22, (1,0)=0x33, (1,1)=0x44; start with out_ready=1. Required response: beat 0x1122 with row 0 at cycle+1, then beat 0x3344 with row 1 and out_last at cycle+2, then tile_clr at cycle+3 only.
REQ-033 Case: the same stimulus with out_ready low for 3 cycles on row 0. Required response: out_data=0x1122 held for 4 cycles and no row skipped.
REQ-034 Case: OUT_WIDTH=6 with elements 0x7F, 0x80, 0x05, 0xFB. Required response: emitted values 0x1F, 0x20, 0x05, 0x3B (+31, -32, +5, -5).
REQ-035 Case: a second start pulse during DRAIN. Required response: it is ignored, and exactly 2 beats and 1 tile_clr are produced.
REQ-036 Case: rst asserted after the first handshake. Required response: all outputs are 0 on the next cycle, there is no tile_clr, and a new start replays from row 0.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared types for the systolic tile datapath: drain FSM states and width helpers.
package tpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } drain_state_t;

  // Row index width; a single-row tile still gets a 1-bit index.
  function automatic int row_w(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/tile_drain_if.sv
// Beat stream carrying one narrowed tile row per transfer, valid/ready handshake.
interface tile_drain_if
  import tpu_pkg::*;
#(
  parameter int M         = 64,
  parameter int N         = 64,
  parameter int OUT_WIDTH = 32
) ();

  localparam int RW = row_w(M);

  logic [0:N*OUT_WIDTH-1] out_data;
  logic [RW-1:0]          out_row;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_last;

  modport master (
    output out_data, out_row, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  out_data, out_row, out_valid, out_last,
    output out_ready
  );

endinterface

// File: rtl/tile_drain_sat_narrow.sv
// Signed saturating narrowing of one accumulator element to the emitted width.
module sat_narrow #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 32
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  // When OUT_W == IN_W these bounds are the full range, so the clamp never fires.
  localparam logic signed [IN_W-1:0] MAXV = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MINV = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  function automatic logic signed [OUT_W-1:0] sat(input logic signed [IN_W-1:0] v);
    if (v > MAXV)      return MAXV[OUT_W-1:0];
    else if (v < MINV) return MINV[OUT_W-1:0];
    else               return v[OUT_W-1:0];
  endfunction

  assign dout = sat(din);

endmodule

// File: rtl/tile_drain.sv
// Drains a frozen systolic tile row by row onto a valid/ready stream, then pulses a clear.
module tile_drain
  import tpu_pkg::*;
#(
  parameter int M           = 64,
  parameter int N           = 64,
  parameter int INPUT_WIDTH = 16,
  parameter int OUT_WIDTH   = 2*INPUT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [0:M*N*2*INPUT_WIDTH-1]  acc_in,
  output logic                          tile_freeze,
  output logic                          tile_clr,
  output logic                          busy,
  tile_drain_if.master                  beat
);

  localparam int AW = 2*INPUT_WIDTH;
  localparam int RW = row_w(M);
  localparam int CW = $clog2(M+1);

  drain_state_t state_p0, state_nxt;
  logic [CW-1:0] cnt_p0, cnt_nxt;
  logic [CW-1:0] row_idx;
  logic          load;
  logic          vld_nxt;
  logic          hs;

  logic signed [AW-1:0]        row_raw_p0 [N];
  logic signed [OUT_WIDTH-1:0] row_nar_p0 [N];

  assign hs          = beat.out_valid & beat.out_ready;
  assign busy        = (state_p0 != IDLE);
  assign tile_freeze = (state_p0 != IDLE);
  assign tile_clr    = (state_p0 == CLEAR);

  // Row 0 is launched straight from IDLE; afterwards the counter names the next row.
  always_comb begin
    row_idx = '0;
    if (state_p0 != IDLE && cnt_p0 < CW'(M))
      row_idx = cnt_p0;
  end

  always_comb begin
    for (int j = 0; j < N; j++) begin
      row_raw_p0[j] = acc_in[(int'(row_idx)*N + j)*AW +: AW];
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_nar
    sat_narrow #(
      .IN_W  (AW),
      .OUT_W (OUT_WIDTH)
    ) u_sat (
      .din  (row_raw_p0[j]),
      .dout (row_nar_p0[j])
    );
  end

  always_comb begin
    state_nxt = state_p0;
    cnt_nxt   = cnt_p0;
    vld_nxt   = beat.out_valid;
    load      = 1'b0;
    case (state_p0)
      IDLE: begin
        if (start) begin
          state_nxt = DRAIN;
          cnt_nxt   = CW'(1);
          vld_nxt   = 1'b1;
          load      = 1'b1;
        end
      end
      DRAIN: begin
        if (hs) begin
          if (beat.out_last) begin
            state_nxt = CLEAR;
            vld_nxt   = 1'b0;
          end else if (cnt_p0 < CW'(M)) begin
            cnt_nxt = cnt_p0 + CW'(1);
            load    = 1'b1;
          end
        end
      end
      CLEAR: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        vld_nxt   = 1'b0;
      end
    endcase
  end

  // Output beat register: loads on launch or accepted beat, otherwise holds under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0       <= IDLE;
      cnt_p0         <= '0;
      beat.out_valid <= 1'b0;
      beat.out_data  <= '0;
      beat.out_row   <= '0;
      beat.out_last  <= 1'b0;
    end else begin
      state_p0       <= state_nxt;
      cnt_p0         <= cnt_nxt;
      beat.out_valid <= vld_nxt;
      if (load) begin
        for (int j = 0; j < N; j++) begin
          beat.out_data[j*OUT_WIDTH +: OUT_WIDTH] <= row_nar_p0[j];
        end
        beat.out_row  <= RW'(row_idx);
        beat.out_last <= (row_idx == CW'(M-1));
      end
    end
  end

endmodule

// File: tb/tb_tile_drain.sv
// Directed bench for tile_drain: M=2, N=2, INPUT_WIDTH=4, full-width and 6-bit outputs.
module tb_tile_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ready;
  logic [0:31] acc;

  logic freeze8, clr8, busy8;
  logic freeze6, clr6, busy6;

  int tests = 0;
  int fails = 0;
  int hs_cnt = 0;
  int clr_cnt = 0;
  int hs_base;
  int clr_base;

  always #5 clk = ~clk;

  tile_drain_if #(.M(2), .N(2), .OUT_WIDTH(8)) if8 ();
  tile_drain_if #(.M(2), .N(2), .OUT_WIDTH(6)) if6 ();

  assign if8.out_ready = ready;
  assign if6.out_ready = ready;

  tile_drain #(.M(2), .N(2), .INPUT_WIDTH(4), .OUT_WIDTH(8)) dut8 (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .acc_in      (acc),
    .tile_freeze (freeze8),
    .tile_clr    (clr8),
    .busy        (busy8),
    .beat        (if8.master)
  );

  tile_drain #(.M(2), .N(2), .INPUT_WIDTH(4), .OUT_WIDTH(6)) dut6 (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .acc_in      (acc),
    .tile_freeze (freeze6),
    .tile_clr    (clr6),
    .busy        (busy6),
    .beat        (if6.master)
  );

  always @(posedge clk) begin
    if (if8.out_valid && if8.out_ready) hs_cnt <= hs_cnt + 1;
    if (clr8) clr_cnt <= clr_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"},  64'(if8.out_valid), 64'd0);
    check({tag, "_freeze"}, 64'(freeze8),       64'd0);
    check({tag, "_clr"},    64'(clr8),          64'd0);
    check({tag, "_busy"},   64'(busy8),         64'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    ready = 1'b1;
    acc   = 32'h11223344;
    tick();
    tick();
    check_idle("rst");
    check("rst_data", 64'(if8.out_data), 64'h0);
    check("rst_row",  64'(if8.out_row),  64'h0);
    check("rst_last", 64'(if8.out_last), 64'h0);
    check("rst_data6", 64'(if6.out_data), 64'h0);

    // Basic drain at full rate.
    rst = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b0_valid",  64'(if8.out_valid), 64'd1);
    check("b0_data",   64'(if8.out_data),  64'h1122);
    check("b0_row",    64'(if8.out_row),   64'd0);
    check("b0_last",   64'(if8.out_last),  64'd0);
    check("b0_freeze", 64'(freeze8),       64'd1);
    check("b0_busy",   64'(busy8),         64'd1);
    check("b0_clr",    64'(clr8),          64'd0);
    tick();
    check("b1_valid", 64'(if8.out_valid), 64'd1);
    check("b1_data",  64'(if8.out_data),  64'h3344);
    check("b1_row",   64'(if8.out_row),   64'd1);
    check("b1_last",  64'(if8.out_last),  64'd1);
    check("b1_clr",   64'(clr8),          64'd0);
    tick();
    check("clr_valid",  64'(if8.out_valid), 64'd0);
    check("clr_pulse",  64'(clr8),          64'd1);
    check("clr_freeze", 64'(freeze8),       64'd1);
    check("clr_busy",   64'(busy8),         64'd1);
    tick();
    check_idle("post");

    // Backpressure on row 0 for three edges.
    ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp_data%0d", k),  64'(if8.out_data),  64'h1122);
      check($sformatf("bp_row%0d", k),   64'(if8.out_row),   64'd0);
      check($sformatf("bp_valid%0d", k), 64'(if8.out_valid), 64'd1);
      check($sformatf("bp_last%0d", k),  64'(if8.out_last),  64'd0);
      if (k < 3) tick();
    end
    ready = 1'b1;
    tick();
    check("bp_b1_data", 64'(if8.out_data), 64'h3344);
    check("bp_b1_row",  64'(if8.out_row),  64'd1);
    check("bp_b1_last", 64'(if8.out_last), 64'd1);
    tick();
    check("bp_clr", 64'(clr8), 64'd1);
    tick();
    check_idle("bp_post");

    // Second start while draining is ignored.
    hs_base  = hs_cnt;
    clr_base = clr_cnt;
    start = 1'b1;
    tick();
    check("rs_b0_data", 64'(if8.out_data), 64'h1122);
    tick();
    start = 1'b0;
    check("rs_b1_row", 64'(if8.out_row), 64'd1);
    tick();
    check("rs_clr", 64'(clr8), 64'd1);
    tick();
    tick();
    tick();
    check_idle("rs_post");
    check("rs_beats", 64'(hs_cnt - hs_base),   64'd2);
    check("rs_clrs",  64'(clr_cnt - clr_base), 64'd1);

    // Reset after the first handshake aborts without a clear.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("ab_row1", 64'(if8.out_row), 64'd1);
    clr_base = clr_cnt;
    rst = 1'b1;
    tick();
    check_idle("ab");
    check("ab_data", 64'(if8.out_data), 64'h0);
    check("ab_row",  64'(if8.out_row),  64'h0);
    check("ab_last", 64'(if8.out_last), 64'h0);
    rst = 1'b0;
    tick();
    tick();
    check("ab_noclr", 64'(clr_cnt - clr_base), 64'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ab_re_data", 64'(if8.out_data), 64'h1122);
    check("ab_re_row",  64'(if8.out_row),  64'd0);
    tick();
    check("ab_re_b1", 64'(if8.out_data), 64'h3344);
    tick();
    check("ab_re_clr", 64'(clr8), 64'd1);
    tick();

    // Saturation to 6 bits: +127 -> +31, -128 -> -32, +5, -5.
    acc   = 32'h7F8005FB;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("sat_e00", 64'(if6.out_data[0 +: 6]), 64'h1F);
    check("sat_e01", 64'(if6.out_data[6 +: 6]), 64'h20);
    check("full_r0", 64'(if8.out_data),         64'h7F80);
    tick();
    check("sat_e10", 64'(if6.out_data[0 +: 6]), 64'h05);
    check("sat_e11", 64'(if6.out_data[6 +: 6]), 64'h3B);
    check("sat_last", 64'(if6.out_last),        64'd1);
    check("full_r1", 64'(if8.out_data),         64'h05FB);
    tick();
    check("sat_clr", 64'(clr6), 64'd1);
    tick();
    check("sat_idle", 64'(busy6), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
